// File: rtl/apb_gpio_blink.sv
// APB-attached GPIO block: per-channel output/enable, hardware blink from a shared
// divider, synchronised inputs with edge-triggered sticky interrupts.
module apb_gpio_blink #(
    parameter int NUM_CH = 28,
    parameter int DIV_W  = 24
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    input  logic [NUM_CH-1:0] gpio_in,
    output logic [NUM_CH-1:0] gpio_out,
    output logic [NUM_CH-1:0] gpio_oe,
    output logic [NUM_CH-1:0] irq
);

    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_OE       = 3'd1;
    localparam logic [2:0] REG_IN       = 3'd2;
    localparam logic [2:0] REG_BLINK_EN = 3'd3;
    localparam logic [2:0] REG_DIV      = 3'd4;
    localparam logic [2:0] REG_INT_EN   = 3'd5;
    localparam logic [2:0] REG_INT_POL  = 3'd6;
    localparam logic [2:0] REG_INT_STAT = 3'd7;

    logic [NUM_CH-1:0] out_reg;
    logic [NUM_CH-1:0] oe_reg;
    logic [NUM_CH-1:0] blink_en_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [NUM_CH-1:0] int_en_reg;
    logic [NUM_CH-1:0] int_pol_reg;
    logic [NUM_CH-1:0] int_stat_reg;
    logic [NUM_CH-1:0] stat_next;

    logic [NUM_CH-1:0] sync1_reg;
    logic [NUM_CH-1:0] sync2_reg;
    logic [NUM_CH-1:0] prev_reg;
    logic [2:0]        vld_reg;

    logic [DIV_W-1:0]  cnt_reg;
    logic [DIV_W-1:0]  cnt_next;
    logic              phase_reg;
    logic              phase_next;
    logic [NUM_CH-1:0] gpio_out_next;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] stat_set;

    logic       wr_en;
    logic       in_range;
    logic [2:0] reg_idx;
    logic       wr_out;
    logic       wr_oe;
    logic       wr_blink_en;
    logic       wr_div;
    logic       wr_int_en;
    logic       wr_int_pol;
    logic       wr_int_stat;
    logic       edge_ok;
    logic       unused_bits;

    assign wr_en       = psel & penable & pwrite;
    assign in_range    = (paddr[7:5] == 3'b000);
    assign reg_idx     = paddr[4:2];
    assign wr_out      = wr_en & in_range & (reg_idx == REG_OUT);
    assign wr_oe       = wr_en & in_range & (reg_idx == REG_OE);
    assign wr_blink_en = wr_en & in_range & (reg_idx == REG_BLINK_EN);
    assign wr_div      = wr_en & in_range & (reg_idx == REG_DIV);
    assign wr_int_en   = wr_en & in_range & (reg_idx == REG_INT_EN);
    assign wr_int_pol  = wr_en & in_range & (reg_idx == REG_INT_POL);
    assign wr_int_stat = wr_en & in_range & (reg_idx == REG_INT_STAT);
    assign unused_bits = ^{paddr[1:0], pwdata};

    // Edges only count once prev holds a real sample, so a pad already high
    // when reset releases never looks like a rising edge.
    assign edge_ok = vld_reg[2];
    assign rise    = sync2_reg & ~prev_reg;
    assign fall    = ~sync2_reg & prev_reg;

    always_comb begin
        cnt_next   = cnt_reg + DIV_W'(1);
        phase_next = phase_reg;
        if (wr_div) begin
            cnt_next = '0;
        end else if (cnt_reg == div_reg) begin
            cnt_next   = '0;
            phase_next = ~phase_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign gpio_out_next[gi] = blink_en_reg[gi] ? phase_reg : out_reg[gi];
            assign stat_set[gi]  = edge_ok & int_en_reg[gi] &
                                   (int_pol_reg[gi] ? rise[gi] : fall[gi]);
            // A new qualifying edge beats a simultaneous write-one-to-clear.
            assign stat_next[gi] = stat_set[gi] |
                                   (int_stat_reg[gi] & ~(wr_int_stat & pwdata[gi]));
        end
    endgenerate

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            out_reg      <= '0;
            oe_reg       <= '0;
            blink_en_reg <= '0;
            div_reg      <= '0;
            int_en_reg   <= '0;
            int_pol_reg  <= '0;
            int_stat_reg <= '0;
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            prev_reg     <= '0;
            vld_reg      <= '0;
            cnt_reg      <= '0;
            phase_reg    <= 1'b0;
            gpio_out     <= '0;
            gpio_oe      <= '0;
        end else begin
            if (wr_out)      out_reg      <= pwdata[NUM_CH-1:0];
            if (wr_oe)       oe_reg       <= pwdata[NUM_CH-1:0];
            if (wr_blink_en) blink_en_reg <= pwdata[NUM_CH-1:0];
            if (wr_div)      div_reg      <= pwdata[DIV_W-1:0];
            if (wr_int_en)   int_en_reg   <= pwdata[NUM_CH-1:0];
            if (wr_int_pol)  int_pol_reg  <= pwdata[NUM_CH-1:0];
            int_stat_reg <= stat_next;
            sync1_reg    <= gpio_in;
            sync2_reg    <= sync1_reg;
            prev_reg     <= sync2_reg;
            vld_reg      <= {vld_reg[1:0], 1'b1};
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
            gpio_out     <= gpio_out_next;
            gpio_oe      <= oe_reg;
        end
    end

    assign irq = int_stat_reg & int_en_reg;

    always_comb begin
        prdata = '0;
        if (psel && !pwrite && in_range) begin
            case (reg_idx)
                REG_OUT:      prdata[NUM_CH-1:0] = out_reg;
                REG_OE:       prdata[NUM_CH-1:0] = oe_reg;
                REG_IN:       prdata[NUM_CH-1:0] = sync2_reg;
                REG_BLINK_EN: prdata[NUM_CH-1:0] = blink_en_reg;
                REG_DIV:      prdata[DIV_W-1:0]  = div_reg;
                REG_INT_EN:   prdata[NUM_CH-1:0] = int_en_reg;
                REG_INT_POL:  prdata[NUM_CH-1:0] = int_pol_reg;
                REG_INT_STAT: prdata[NUM_CH-1:0] = int_stat_reg;
                default:      prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_gpio_blink.sv
// Directed bench: a default-sized instance plus an 8-channel instance sharing one APB bus.
module tb_apb_gpio_blink;

    localparam logic [7:0] A_OUT      = 8'h00;
    localparam logic [7:0] A_OE       = 8'h04;
    localparam logic [7:0] A_IN       = 8'h08;
    localparam logic [7:0] A_BLINK_EN = 8'h0C;
    localparam logic [7:0] A_DIV      = 8'h10;
    localparam logic [7:0] A_INT_EN   = 8'h14;
    localparam logic [7:0] A_INT_POL  = 8'h18;
    localparam logic [7:0] A_INT_STAT = 8'h1C;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel_a;
    logic        psel_b;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata_a;
    logic [31:0] prdata_b;
    logic [27:0] gpio_in_a;
    logic [27:0] gpio_out_a;
    logic [27:0] gpio_oe_a;
    logic [27:0] irq_a;
    logic [7:0]  gpio_in_b;
    logic [7:0]  gpio_out_b;
    logic [7:0]  gpio_oe_b;
    logic [7:0]  irq_b;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_gpio_blink dut_a (
        .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
        .gpio_in(gpio_in_a), .gpio_out(gpio_out_a), .gpio_oe(gpio_oe_a), .irq(irq_a)
    );

    apb_gpio_blink #(.NUM_CH(8), .DIV_W(8)) dut_b (
        .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
        .gpio_in(gpio_in_b), .gpio_out(gpio_out_b), .gpio_oe(gpio_oe_b), .irq(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Returns #1 after the commit edge.
    task automatic apb_wr(input bit b, input logic [7:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; penable = 1'b0;
        if (b) psel_b = 1'b1; else psel_a = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_chk(input bit b, input logic [7:0] a, input string tag,
                          input logic [31:0] exp);
        logic [31:0] d;
        paddr = a; pwrite = 1'b0; penable = 1'b0;
        if (b) psel_b = 1'b1; else psel_a = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        #1 d = b ? prdata_b : prdata_a;
        @(posedge pclk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        chk(tag, d, exp);
    endtask

    initial begin
        int m;
        int n;
        logic e;
        presetn = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in_a = '0; gpio_in_b = '0;

        repeat (3) @(posedge pclk);
        #1;
        chk("rst_gpio_out", 32'(gpio_out_a), 32'h0);
        chk("rst_gpio_oe",  32'(gpio_oe_a),  32'h0);
        chk("rst_irq",      32'(irq_a),      32'h0);
        chk("rst_prdata_idle", prdata_a, 32'h0);

        // Phase toggles on the first edge after release (div = 0), then the
        // BLINK_DIV commit clears cnt and leaves phase at 1.
        presetn = 1'b1;
        apb_wr(0, A_DIV, 32'd3);
        apb_wr(0, A_BLINK_EN, 32'h1);
        m = 2;
        repeat (10) begin
            @(posedge pclk); #1;
            m++;
            e = 1'b1 ^ ((((m - 1) / 4) % 2) == 1);
            chk($sformatf("blink_m%0d", m), 32'(gpio_out_a[0]), 32'(e));
        end
        // Restart: phase held at 0 at the commit, next toggle four edges later.
        apb_wr(0, A_DIV, 32'd3);
        n = 0;
        repeat (9) begin
            @(posedge pclk); #1;
            n++;
            e = ((((n - 1) / 4) % 2) == 1);
            chk($sformatf("blink_restart_n%0d", n), 32'(gpio_out_a[0]), 32'(e));
        end
        rd_chk(0, A_DIV, "rd_div", 32'd3);
        apb_wr(0, A_BLINK_EN, 32'h0);

        apb_wr(0, A_OUT, 32'h5);
        chk("out_same_edge", 32'(gpio_out_a), 32'h0);
        @(posedge pclk); #1;
        chk("out_next_edge", 32'(gpio_out_a), 32'h5);
        apb_wr(0, A_OE, 32'hF);
        chk("oe_same_edge", 32'(gpio_oe_a), 32'h0);
        @(posedge pclk); #1;
        chk("oe_next_edge", 32'(gpio_oe_a), 32'hF);
        rd_chk(0, A_OUT, "rd_out", 32'h5);
        rd_chk(0, A_OE,  "rd_oe",  32'hF);
        rd_chk(0, 8'h40, "rd_unmapped_a", 32'h0);
        apb_wr(0, 8'h20, 32'hFFFF_FFFF);
        rd_chk(0, A_OUT, "rd_out_after_unmapped_wr", 32'h5);

        apb_wr(0, A_INT_POL, 32'h4);
        apb_wr(0, A_INT_EN,  32'h4);
        gpio_in_a[2] = 1'b1;
        gpio_in_a[3] = 1'b1;
        @(posedge pclk); #1;
        chk("irq_k", 32'(irq_a), 32'h0);
        @(posedge pclk); #1;
        chk("irq_k1", 32'(irq_a), 32'h0);
        @(posedge pclk); #1;
        chk("irq_k2", 32'(irq_a), 32'h4);
        rd_chk(0, A_INT_STAT, "rd_stat_rise", 32'h4);
        apb_wr(0, A_INT_STAT, 32'h4);
        chk("irq_after_w1c", 32'(irq_a), 32'h0);
        gpio_in_a[2] = 1'b0;
        gpio_in_a[3] = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        chk("irq_fall_ignored", 32'(irq_a), 32'h0);
        rd_chk(0, A_INT_STAT, "rd_stat_fall", 32'h0);

        gpio_in_a[2] = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("irq_pending", 32'(irq_a), 32'h4);
        gpio_in_a[2] = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        // Rise captured now; its set lands on the same edge as the W1C commit.
        gpio_in_a[2] = 1'b1;
        @(posedge pclk); #1;
        apb_wr(0, A_INT_STAT, 32'h4);
        chk("irq_set_beats_w1c", 32'(irq_a), 32'h4);
        rd_chk(0, A_INT_STAT, "rd_stat_set_wins", 32'h4);

        apb_wr(0, A_INT_EN, 32'h0);
        chk("irq_masked", 32'(irq_a), 32'h0);
        rd_chk(0, A_INT_STAT, "rd_stat_masked", 32'h4);
        apb_wr(0, A_INT_EN, 32'h4);
        chk("irq_unmasked", 32'(irq_a), 32'h4);

        apb_wr(0, A_BLINK_EN, 32'h1);
        repeat (2) @(posedge pclk);
        #3 presetn = 1'b0;
        #1;
        chk("rst_mid_gpio_out", 32'(gpio_out_a), 32'h0);
        chk("rst_mid_gpio_oe",  32'(gpio_oe_a),  32'h0);
        chk("rst_mid_irq",      32'(irq_a),      32'h0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        repeat (6) begin
            @(posedge pclk); #1;
            if (gpio_out_a !== '0 || gpio_oe_a !== '0 || irq_a !== '0)
                chk("post_rst_glitch", {gpio_out_a[3:0], gpio_oe_a[3:0], irq_a[3:0]}, 32'h0);
        end
        chk("post_rst_outputs", {gpio_out_a[3:0], gpio_oe_a[3:0], irq_a[3:0]}, 32'h0);
        rd_chk(0, A_INT_STAT, "rd_stat_after_rst", 32'h0);
        rd_chk(0, A_BLINK_EN, "rd_blink_en_after_rst", 32'h0);

        gpio_in_a = 28'h0AB_CDEF;
        repeat (3) @(posedge pclk);
        #1;
        rd_chk(0, A_IN, "rd_in", 32'h00AB_CDEF);

        apb_wr(1, A_OUT, 32'hFFFF_FFFF);
        @(posedge pclk); #1;
        chk("b_gpio_out", 32'(gpio_out_b), 32'hFF);
        rd_chk(1, A_OUT, "b_rd_out", 32'h0000_00FF);
        rd_chk(1, 8'h40, "b_rd_unmapped", 32'h0);
        apb_wr(1, A_DIV, 32'hFFFF_FFFF);
        rd_chk(1, A_DIV, "b_rd_div", 32'h0000_00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
